// File: rtl/audio_pkg.sv
// Shared audio datapath types: Q15 sample type and I2S frame geometry.
package audio_pkg;

  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned I2S_SLOTS = 32;
  localparam int unsigned SLOT_W    = $clog2(I2S_SLOTS);

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Word select leads each channel's MSB by one BCLK: high for slots 15..30.
  function automatic logic lrclk_for_slot(input logic [SLOT_W-1:0] slot);
    return (slot >= SLOT_W'(I2S_SLOTS / 2 - 1)) && (slot <= SLOT_W'(I2S_SLOTS - 2));
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO; a pop in the same cycle frees room for a push when full.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = SAMPLE_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Full+pop writes the slot being read; the pop still sees the old head.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: buffers mono samples and sends each as a left/right-duplicated frame.
module i2s_tx #(
  parameter int unsigned SAMPLE_W   = audio_pkg::SAMPLE_W,
  parameter int unsigned BCLK_HALF  = 47,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [SAMPLE_W-1:0]         s_in,
  input  logic                        s_in_valid,
  input  logic                        clear_flags,
  output logic                        i2s_bclk,
  output logic                        i2s_lrclk,
  output logic                        i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        underflow
);

  import audio_pkg::I2S_SLOTS;
  import audio_pkg::SLOT_W;
  import audio_pkg::lrclk_for_slot;

  localparam int unsigned DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int unsigned HALF_SLOTS = I2S_SLOTS / 2;
  localparam logic [DIV_W-1:0]  DIV_TC    = DIV_W'(BCLK_HALF - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(I2S_SLOTS - 1);

  // Both channel halves walk the same sample MSB-first.
  function automatic logic frame_bit(input logic [SAMPLE_W-1:0] f,
                                     input logic [SLOT_W-1:0]   s);
    logic [SAMPLE_W-1:0] sh;
    sh = f << (32'(s) % HALF_SLOTS);
    return sh[SAMPLE_W-1];
  endfunction

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                bclk_q, bclk_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic [SAMPLE_W-1:0] frame_q, frame_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  logic                div_tc, fall_ev, frame_start;
  logic                pop, fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head;

  assign div_tc      = (div_cnt_q == DIV_TC);
  assign fall_ev     = enable && div_tc && bclk_q;
  assign frame_start = fall_ev && (slot_q == LAST_SLOT);
  assign pop         = frame_start && !fifo_empty;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (s_in_valid),
    .pop_i   (pop),
    .wdata_i (s_in),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    div_cnt_d = div_cnt_q;
    slot_d    = slot_q;
    bclk_d    = bclk_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    frame_d   = frame_q;

    if (!enable) begin
      div_cnt_d = '0;
      slot_d    = LAST_SLOT;
      bclk_d    = 1'b0;
      lrclk_d   = 1'b0;
      sdata_d   = 1'b0;
      frame_d   = '0;
    end else begin
      div_cnt_d = div_tc ? '0 : div_cnt_q + 1'b1;
      if (div_tc) bclk_d = ~bclk_q;
      if (fall_ev) begin
        slot_d  = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        lrclk_d = lrclk_for_slot(slot_d);
        if (frame_start) frame_d = fifo_empty ? '0 : fifo_head;
        sdata_d = frame_bit(frame_d, slot_d);
      end
    end
  end

  // Sticky flags: a set condition in the same cycle overrides clear_flags.
  always_comb begin
    ovf_d = clear_flags ? 1'b0 : ovf_q;
    udf_d = clear_flags ? 1'b0 : udf_q;
    if (s_in_valid && fifo_full && !pop) ovf_d = 1'b1;
    if (frame_start && fifo_empty)       udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      slot_q    <= LAST_SLOT;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      frame_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      slot_q    <= slot_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      frame_q   <= frame_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign i2s_bclk  = bclk_q;
  assign i2s_lrclk = lrclk_q;
  assign i2s_sdata = sdata_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: time-based frame model checked every cycle plus directed literal checks.
module tb_i2s_tx;

  localparam int BH    = 2;
  localparam int DEPTH = 4;
  localparam int FR    = 64 * BH;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] s_in = '0;
  logic        s_in_valid = 1'b0;
  logic        clear_flags = 1'b0;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata;
  logic [2:0]  fifo_level;
  logic        overflow, underflow;

  always #5 clk = ~clk;

  i2s_tx #(
    .SAMPLE_W   (16),
    .BCLK_HALF  (BH),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .s_in        (s_in),
    .s_in_valid  (s_in_valid),
    .clear_flags (clear_flags),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: p = enabled clock edges since the serializer last started.
  int          p = 0;
  logic [15:0] mq[$];
  logic [15:0] mframe = '0;
  logic        movf = 1'b0;
  logic        mudf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit start, set_u, set_o;
    if (reset) begin
      p = 0;
      mq.delete();
      mframe = '0;
      movf = 1'b0;
      mudf = 1'b0;
    end else begin
      start = enable && ((p + 1) % (2 * BH) == 0) && ((((p + 1) / (2 * BH)) - 1) % 32 == 0);
      set_u = 1'b0;
      set_o = 1'b0;
      if (start) begin
        if (mq.size() > 0) mframe = mq.pop_front();
        else begin
          mframe = '0;
          set_u = 1'b1;
        end
      end
      if (s_in_valid) begin
        if (mq.size() < DEPTH) mq.push_back(s_in);
        else set_o = 1'b1;
      end
      if (clear_flags) begin
        movf = 1'b0;
        mudf = 1'b0;
      end
      if (set_o) movf = 1'b1;
      if (set_u) mudf = 1'b1;
      if (enable) p++;
      else begin
        p = 0;
        mframe = '0;
      end
    end
  endtask

  function automatic int model_slot();
    return ((p / (2 * BH)) + 31) % 32;
  endfunction

  task automatic compare();
    int   slot;
    logic eb, el, ed;
    slot = model_slot();
    eb = ((p / BH) % 2) == 1;
    el = (slot >= 15) && (slot <= 30);
    ed = mframe[15 - (slot % 16)];
    chk("bclk",      32'(i2s_bclk),   32'(eb));
    chk("lrclk",     32'(i2s_lrclk),  32'(el));
    chk("sdata",     32'(i2s_sdata),  32'(ed));
    chk("level",     32'(fifo_level), mq.size());
    chk("overflow",  32'(overflow),   32'(movf));
    chk("underflow", 32'(underflow),  32'(mudf));
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) compare();
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic write(input logic [15:0] v);
    s_in = v;
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
  endtask

  // Captures sdata/lrclk on every BCLK rise of one frame, indexed bit (31 - slot).
  task automatic capture_frame(output logic [31:0] bits, output logic [31:0] lrs);
    bit   found = 1'b0;
    logic prev = 1'b0;
    int   n = 0;
    int   slot;
    bits = '0;
    lrs  = '0;
    for (int i = 0; i < 3 * FR; i++) begin
      if (p >= 2 * BH && ((p - 2 * BH) % FR) == 0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL frame_wait: got timeout want frame start (t=%0t)", $time);
    end else begin
      for (int i = 0; i < FR; i++) begin
        if (i2s_bclk && !prev) begin
          slot = model_slot();
          bits[31 - slot] = i2s_sdata;
          lrs[31 - slot]  = i2s_lrclk;
          n++;
        end
        prev = i2s_bclk;
        tick();
      end
      chk("rise_count", n, 32);
    end
  endtask

  logic [31:0] bits, lrs;
  logic [15:0] t3 [6];
  int          nfall;
  logic        prevb;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    t3[0] = 16'h1234; t3[1] = 16'hA5C3; t3[2] = 16'h7FFF;
    t3[3] = 16'h8000; t3[4] = 16'hDEAD; t3[5] = 16'hBEEF;

    // Reset values, then one sample MSB-first on both channels
    tick();
    chk_en = 1'b1;
    chk("rst_bclk",  32'(i2s_bclk),   0);
    chk("rst_lrclk", 32'(i2s_lrclk),  0);
    chk("rst_sdata", 32'(i2s_sdata),  0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ovf",   32'(overflow),   0);
    chk("rst_udf",   32'(underflow),  0);
    reset = 1'b0;
    write(16'h8001);
    chk("t1_level", 32'(fifo_level), 1);
    capture_frame(bits, lrs);
    chk("t1_bits", bits, 32'h8001_8001);
    chk("t1_lrclk", lrs, 32'h0001_FFFE);

    // No writes: zero frames and underflow after the first fall event
    do_reset();
    tick(3);
    chk("t2_udf_pre", 32'(underflow), 0);
    tick();
    chk("t2_udf_post", 32'(underflow), 1);
    capture_frame(bits, lrs);
    chk("t2_bits", bits, 32'h0);
    chk("t2_level", 32'(fifo_level), 0);
    pulse_clear();
    chk("t2_udf_clr", 32'(underflow), 0);

    // Six back-to-back writes while idle: four kept, overflow, in-order frames
    enable = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) write(t3[i]);
    chk("t3_level", 32'(fifo_level), 4);
    chk("t3_ovf", 32'(overflow), 1);
    pulse_clear();
    chk("t3_ovf_clr", 32'(overflow), 0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      capture_frame(bits, lrs);
      chk($sformatf("t3_frame%0d", i), bits, {t3[i], t3[i]});
    end
    capture_frame(bits, lrs);
    chk("t3_frame_empty", bits, 32'h0);
    chk("t3_udf", 32'(underflow), 1);

    // Write exactly in the slot-0 fall cycle with the FIFO full
    enable = 1'b0;
    do_reset();
    write(16'h0001); write(16'h0002); write(16'h4000); write(16'hFFFF);
    enable = 1'b1;
    tick(2 * BH - 1);
    write(16'h1357);
    chk("t4a_level", 32'(fifo_level), 4);
    chk("t4a_ovf", 32'(overflow), 0);
    capture_frame(bits, lrs);
    chk("t4a_frame0", bits, 32'h0001_0001);
    capture_frame(bits, lrs);
    capture_frame(bits, lrs);
    capture_frame(bits, lrs);
    capture_frame(bits, lrs);
    chk("t4a_frame4", bits, 32'h1357_1357);

    // Write exactly in the slot-0 fall cycle with the FIFO empty
    do_reset();
    tick(2 * BH - 1);
    write(16'h5A5A);
    chk("t4b_level", 32'(fifo_level), 1);
    chk("t4b_udf", 32'(underflow), 1);
    capture_frame(bits, lrs);
    chk("t4b_frame0", bits, 32'h0);
    capture_frame(bits, lrs);
    chk("t4b_frame1", bits, 32'h5A5A_5A5A);

    // Disable at slot 20, re-enable: fresh frame carrying the FIFO head
    enable = 1'b0;
    do_reset();
    write(16'hC3C3);
    write(16'h9E1E);
    enable = 1'b1;
    tick(21 * 2 * BH);
    chk("t5_slot20_lr", 32'(i2s_lrclk), 1);
    enable = 1'b0;
    tick();
    chk("t5_off_bclk",  32'(i2s_bclk),   0);
    chk("t5_off_lrclk", 32'(i2s_lrclk),  0);
    chk("t5_off_sdata", 32'(i2s_sdata),  0);
    chk("t5_off_level", 32'(fifo_level), 1);
    tick(5);
    enable = 1'b1;
    nfall = 0;
    prevb = i2s_bclk;
    for (int i = 0; i < 20; i++) begin
      tick();
      nfall++;
      if (prevb && !i2s_bclk) break;
      prevb = i2s_bclk;
    end
    chk("t5_first_fall", nfall, 4);
    chk("t5_msb", 32'(i2s_sdata), 1);
    capture_frame(bits, lrs);
    chk("t5_frame", bits, 32'h9E1E_9E1E);
    chk("t5_level", 32'(fifo_level), 0);

    // Reset mid-frame with three samples queued
    enable = 1'b0;
    do_reset();
    write(16'h0420); write(16'h0420); write(16'h0420); write(16'h0420);
    enable = 1'b1;
    tick(46);
    chk("t6_level_pre", 32'(fifo_level), 3);
    chk("t6_bclk_pre",  32'(i2s_bclk),   1);
    reset = 1'b1;
    tick();
    chk("t6_bclk",  32'(i2s_bclk),   0);
    chk("t6_lrclk", 32'(i2s_lrclk),  0);
    chk("t6_sdata", 32'(i2s_sdata),  0);
    chk("t6_level", 32'(fifo_level), 0);
    chk("t6_ovf",   32'(overflow),   0);
    chk("t6_udf",   32'(underflow),  0);
    reset = 1'b0;
    tick(FR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
